// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit.
// FETCH_MISALIGN_CHECK_EN adds a fault bit to each queue entry.
package if_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic                    fault;
`endif
  } fetch_entry_t;

  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side, memory-side and decode-side signals of the fetch unit.
// master is the fetch unit's view; slave is its surroundings.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              flush;
  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_fault;

  modport master (
    input  flush, fetch_valid, fetch_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    input  instr_ready,
    output fetch_ready, mem_req, mem_addr,
    output instr_valid, instr, instr_pc, instr_fault
  );

  modport slave (
    output flush, fetch_valid, fetch_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    output instr_ready,
    input  fetch_ready, mem_req, mem_addr,
    input  instr_valid, instr, instr_pc, instr_fault
  );

endinterface

// File: rtl/instr_fetch_unit_queue.sv
// Small sync FIFO of fetched {pc, instr[, fault]} entries.
// clear empties it on the next edge and overrides push/pop.
module fetch_queue
  import if_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  logic   clear,
  input  entry_t din,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t         mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  assign empty   = count == '0;
  assign full    = count == CW'(DEPTH);
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && !clear && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, wrapping pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory read, queued results.
// FETCH_MISALIGN_CHECK_EN turns misaligned fetches into fault entries.
module instr_fetch_unit
  import if_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic              fault;
`endif
  } entry_t;

  fetch_state_e      state;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ready;
  logic              hs;
  logic              mis;
  logic              rsp_push;
  logic              push;
  logic              full;
  logic              empty;
  entry_t            push_data;
  entry_t            head;

  // A slot is reserved at accept time, so the response always fits.
  assign ready = !reset && (state == IDLE) && !bus.flush && !full;
  assign hs    = bus.fetch_valid && ready;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign mis = misaligned(bus.fetch_addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  assign rsp_push = (state == WAIT) && bus.mem_rvalid && !bus.flush;
  assign push     = rsp_push || (hs && mis);

  // Entry to enqueue: memory response, or a fault for a bad address.
  always_comb begin
    push_data = '0;
    if (rsp_push) begin
      push_data.pc    = addr_q;
      push_data.instr = bus.mem_rdata;
    end else begin
      push_data.pc    = bus.fetch_addr;
`ifdef FETCH_MISALIGN_CHECK_EN
      push_data.fault = 1'b1;
`endif
    end
  end

  // Request FSM with registered mem_req/mem_addr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hs && !mis) begin
            state  <= REQ;
            req_q  <= 1'b1;
            addr_q <= bus.fetch_addr;
          end
        end
        REQ: begin
          // A grant in the flush cycle still returns data; drain it.
          if (bus.mem_gnt) begin
            req_q <= 1'b0;
            state <= bus.flush ? DRAIN : WAIT;
          end else if (bus.flush) begin
            req_q <= 1'b0;
            state <= IDLE;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) state <= IDLE;
          else if (bus.flush) state <= DRAIN;
        end
        DRAIN: begin
          if (bus.mem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fetch_queue #(
    .entry_t (entry_t),
    .DEPTH   (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (bus.instr_ready),
    .clear (bus.flush),
    .din   (push_data),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.fetch_ready = ready;
  assign bus.mem_req     = req_q;
  assign bus.mem_addr    = addr_q;
  assign bus.instr_valid = !empty;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign bus.instr_fault = head.fault;
`else
  assign bus.instr_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic
// checked against a transaction-level model of the fetch pipeline.
module tb_instr_fetch_unit;

  localparam int QD = 2;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instr_fetch_unit #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .QUEUE_DEPTH (QD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        flt;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        pop_log[$];
  bit          wait_gnt, in_mem, alive;
  logic [31:0] req_addr;
  int          lat_left;
  int          gnt_pct = 100;
  int          lat_min = 0;
  int          lat_max = 0;
  bit          use_fix;
  logic [31:0] fix_data;
  bit          stale_rv;
  bit          last_hs;
  int          n_cmp, n_bad;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    wait_gnt = 0;
    in_mem   = 0;
    alive    = 0;
  endtask

  // One clock: drive at negedge, check against the model, advance it.
  task automatic cycle(input bit fv, input logic [31:0] fa,
                       input bit rdy, input bit fl);
    bit gnt, rv, exp_ready;
    logic [31:0] d;
    @(negedge clk);
    bus.fetch_valid = fv;
    bus.fetch_addr  = fa;
    bus.instr_ready = rdy;
    bus.flush       = fl;
    gnt = bus.mem_req && ($urandom_range(99) < gnt_pct);
    rv  = (in_mem && lat_left == 0) || stale_rv;
    d   = use_fix ? fix_data : $urandom;
    bus.mem_gnt    = gnt;
    bus.mem_rvalid = rv;
    bus.mem_rdata  = rv ? d : $urandom;
    #1;
    exp_ready = !fl && !wait_gnt && !in_mem && exp_q.size() < QD;
    check("fetch_ready", 64'(bus.fetch_ready), 64'(exp_ready));
    check("mem_req", 64'(bus.mem_req), 64'(wait_gnt));
    if (wait_gnt) check("mem_addr", 64'(bus.mem_addr), 64'(req_addr));
    check("instr_valid", 64'(bus.instr_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("instr_pc", 64'(bus.instr_pc), 64'(exp_q[0].pc));
      check("instr", 64'(bus.instr), 64'(exp_q[0].ins));
      check("instr_fault", 64'(bus.instr_fault), 64'(exp_q[0].flt));
    end
    last_hs = fv && exp_ready;
    if (exp_q.size() != 0 && rdy && !fl) pop_log.push_back(exp_q.pop_front());
    if (rv && in_mem) begin
      in_mem = 0;
      if (alive && !fl) exp_q.push_back('{pc: req_addr, ins: d, flt: 1'b0});
    end else if (in_mem) begin
      lat_left--;
    end
    if (wait_gnt) begin
      if (gnt) begin
        wait_gnt = 0;
        in_mem   = 1;
        alive    = !fl;
        lat_left = $urandom_range(lat_max, lat_min);
      end else if (fl) begin
        wait_gnt = 0;
      end
    end
    if (fl) begin
      exp_q.delete();
      alive = 0;
    end
    if (last_hs) begin
      if (MIS_EN && fa[1:0] != 2'b00) begin
        exp_q.push_back('{pc: fa, ins: 32'h0, flt: 1'b1});
      end else begin
        wait_gnt = 1;
        req_addr = fa;
      end
    end
    @(posedge clk);
  endtask

  task automatic fetch(input logic [31:0] a, input bit rdy, input string tag);
    int k = 0;
    do begin
      cycle(1'b1, a, rdy, 1'b0);
      k++;
    end while (!last_hs && k < 30);
    check(tag, 64'(last_hs), 64'(1));
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || wait_gnt || in_mem) && k < 60) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      k++;
    end
    check(tag, 64'(exp_q.size() != 0 || wait_gnt || in_mem), 64'(0));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_fetch_ready"}, 64'(bus.fetch_ready), 64'(0));
    check({tag, "_mem_req"}, 64'(bus.mem_req), 64'(0));
    check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(0));
    check({tag, "_instr_valid"}, 64'(bus.instr_valid), 64'(0));
    check({tag, "_instr"}, 64'(bus.instr), 64'(0));
    check({tag, "_instr_pc"}, 64'(bus.instr_pc), 64'(0));
    check({tag, "_instr_fault"}, 64'(bus.instr_fault), 64'(0));
  endtask

  initial begin
    int idx, pops;
    bus.flush       = 0;
    bus.fetch_valid = 0;
    bus.fetch_addr  = 0;
    bus.mem_gnt     = 0;
    bus.mem_rvalid  = 0;
    bus.mem_rdata   = 0;
    bus.instr_ready = 0;
    model_reset();

    // Reset values
    @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    reset = 0;

    // Single fetch with fixed latency
    gnt_pct  = 100;
    use_fix  = 1;
    fix_data = 32'h0050_0093;
    cycle(1'b1, 32'h10, 1'b0, 1'b0);
    check("t1_accept", 64'(last_hs), 64'(1));
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    #1 check("t1_n2_empty", 64'(bus.instr_valid), 64'(0));
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("t1_n3_valid", 64'(bus.instr_valid), 64'(1));
    check("t1_instr", 64'(bus.instr), 64'h0050_0093);
    check("t1_pc", 64'(bus.instr_pc), 64'h10);
    drain("t1_drain");

    // Backpressure: two accepted, third waits for a pop
    use_fix = 0;
    lat_max = 1;
    idx = 0;
    pop_log.delete();
    for (int c = 0; c < 16; c++) begin
      cycle(idx < 3, 32'(idx * 4), 1'b0, 1'b0);
      if (last_hs) idx++;
    end
    check("bp_accepted", 64'(idx), 64'(2));
    #1 check("bp_ready_low", 64'(bus.fetch_ready), 64'(0));
    cycle(1'b1, 32'h8, 1'b1, 1'b0);
    if (last_hs) idx++;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      cycle(1'b1, 32'h8, 1'b0, 1'b0);
      if (last_hs) idx++;
    end
    check("bp_third", 64'(idx), 64'(3));
    drain("bp_drain");
    check("bp_count", 64'(pop_log.size()), 64'(3));
    for (int i = 0; i < 3 && i < pop_log.size(); i++)
      check("bp_order", 64'(pop_log[i].pc), 64'(i * 4));

    // Grant stall
    pop_log.delete();
    gnt_pct = 0;
    fetch(32'h20, 1'b0, "gs_accept");
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      check("gs_req", 64'(bus.mem_req), 64'(1));
      check("gs_addr", 64'(bus.mem_addr), 64'h20);
    end
    gnt_pct = 100;
    drain("gs_drain");
    check("gs_count", 64'(pop_log.size()), 64'(1));
    if (pop_log.size() != 0) check("gs_pc", 64'(pop_log[0].pc), 64'h20);

    // Flush while waiting for data
    pop_log.delete();
    lat_min  = 1;
    lat_max  = 1;
    use_fix  = 1;
    fix_data = 32'hDEAD_BEEF;
    fetch(32'h80, 1'b0, "fw_accept");
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    #1 check("fw_discard", 64'(bus.instr_valid), 64'(0));
    fix_data = 32'h1111_2222;
    fetch(32'h100, 1'b0, "fw_next");
    drain("fw_drain");
    check("fw_count", 64'(pop_log.size()), 64'(1));
    if (pop_log.size() != 0) begin
      check("fw_pc", 64'(pop_log[0].pc), 64'h100);
      check("fw_data", 64'(pop_log[0].ins), 64'h1111_2222);
    end

    // Async reset mid-WAIT with one entry queued
    lat_min = 5;
    lat_max = 5;
    fetch(32'h200, 1'b0, "ar_first");
    for (int c = 0; c < 10 && exp_q.size() == 0; c++)
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
    fetch(32'h204, 1'b0, "ar_second");
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset = 1;
    #1 check_outputs_zero("ar");
    model_reset();
    @(negedge clk);
    reset = 0;
    stale_rv = 1;
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    stale_rv = 0;
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    #1 check("ar_stale", 64'(bus.instr_valid), 64'(0));

    // Misaligned address
    lat_min = 0;
    lat_max = 0;
    fix_data = 32'h0000_0013;
    fetch(32'h6, 1'b0, "mis_accept");
    #1;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_no_req", 64'(bus.mem_req), 64'(0));
    check("mis_valid", 64'(bus.instr_valid), 64'(1));
    check("mis_pc", 64'(bus.instr_pc), 64'h6);
    check("mis_instr", 64'(bus.instr), 64'h0);
    check("mis_fault", 64'(bus.instr_fault), 64'(1));
`else
    check("mis_req", 64'(bus.mem_req), 64'(1));
    check("mis_addr", 64'(bus.mem_addr), 64'h6);
`endif
    drain("mis_drain");

    // Random traffic
    use_fix = 0;
    gnt_pct = 70;
    lat_max = 3;
    pop_log.delete();
    for (int c = 0; c < 2000; c++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(9) != 0) a[1:0] = 2'b00;
      cycle($urandom_range(1) == 1, a, $urandom_range(3) != 0,
            $urandom_range(19) == 0);
    end
    drain("rnd_drain");
    pops = pop_log.size();
    check("rnd_progress", 64'(pops > 50), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Memory-side consumer of the program counter address.
- Takes a fetch address from the PC stage, issues one instruction read to instruction memory, and waits a variable number of cycles for the data.
- Buffers returned words with their PC in a small queue and presents them to decode with a valid/ready handshake.
- A flush (branch/jump redirect) discards queued and in-flight instructions.

Parameters:
- ADDR_W, 32, fetch/memory address width in bits.
- DATA_W, 32, instruction width in bits.
- QUEUE_DEPTH, 2, entries in the {pc, instr} output queue; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  redirect pulse; drop all queued and in-flight fetches.
- fetch_valid  in  1  PC stage offers fetch_addr.
- fetch_addr  in  ADDR_W  byte address of the instruction to fetch.
- fetch_ready  out  1  unit accepts fetch_addr this cycle.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  ADDR_W  read address; held stable while mem_req=1 and mem_gnt=0.
- mem_gnt  in  1  memory accepted the request.
- mem_rvalid  in  1  read data valid, one cycle, at least 1 cycle after the grant.
- mem_rdata  in  DATA_W  read data.
- instr_valid  out  1  queue head valid.
- instr_ready  in  1  decode consumes the head.
- instr  out  DATA_W  queue head instruction.
- instr_pc  out  ADDR_W  queue head address.
- instr_fault  out  1  queue head is a misaligned-fetch fault (see Optional Feature).

Behaviour:
- Reset (async): FSM=IDLE, queue empty, all outputs 0 (fetch_ready=0, mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0, instr_fault=0). Reset mid-transaction abandons it; a later mem_rvalid is ignored while in IDLE.
- FSM states: IDLE, REQ, WAIT, DRAIN.
  - IDLE: fetch_ready = !flush && (occupancy < QUEUE_DEPTH). On a fetch handshake, latch the address into mem_addr and go to REQ.
  - REQ: mem_req=1. mem_gnt=1 goes to WAIT. flush in REQ drops the request (mem_req deasserts next cycle) and goes to IDLE.
  - WAIT: mem_rvalid=1 pushes {mem_addr, mem_rdata, fault=0} and goes to IDLE. flush in WAIT goes to DRAIN. If mem_rvalid and flush occur in the same cycle, the data is discarded and the next state is IDLE.
  - DRAIN: the next mem_rvalid is discarded; then go to IDLE. fetch_ready=0 in DRAIN.
- At most one memory request is outstanding. Slot reservation: a fetch is accepted only when occupancy < QUEUE_DEPTH, so the response always fits and no overflow is possible.
- Latency: fetch accepted at cycle N, mem_req at N+1; with gnt at N+1 and rvalid at N+2, instr_valid=1 at N+3.
- Output: instr/instr_pc/instr_fault are registered queue-head fields. The head pops on instr_valid && instr_ready.
- Push and pop in the same cycle keeps occupancy unchanged. Pointers wrap modulo QUEUE_DEPTH.
- flush: the queue empties on the next edge (instr_valid=0 the cycle after flush). A same-cycle pop is ignored. fetch_ready=0 while flush=1.
- Addresses pass through unmodified; no PC arithmetic is done here.

Optional Feature:
- Macro FETCH_MISALIGN_CHECK_EN.
- Defined: an accepted fetch_addr with addr[1:0]!=0 issues no memory request. Push {addr, instr=0, fault=1} directly from IDLE, taking 1 cycle. instr_fault follows the head entry.
- Undefined: no check. Every accepted address goes to memory, and instr_fault is tied 0. No fault storage bit in the queue.

Decomposition:
- Package if_pkg: fetch_state_e enum (IDLE, REQ, WAIT, DRAIN) and fetch_entry_t struct {pc, instr, fault}.
- One natural sub-module: fetch_queue. Parameterised sync FIFO of fetch_entry_t with push, pop, clear (flush), count, full, empty; asynchronous reset.

Test Plan:
- Single fetch, addr 0x0000_0010, gnt same cycle, rvalid 1 cycle later with 0x0050_0093 -> instr_valid=1 with instr=0x0050_0093, instr_pc=0x10, 3 cycles after the handshake.
- Backpressure: instr_ready=0, fetch 0x0,0x4,0x8 -> two accepted, fetch_ready=0 at occupancy 2. Pop once -> 0x8 accepted; outputs in order 0x0,0x4,0x8.
- Grant stall: mem_gnt=0 for 4 cycles at addr 0x20 -> mem_req and mem_addr=0x20 held stable; after the grant, the response is delivered normally.
- Flush in WAIT: flush after the grant, rvalid 2 cycles later with 0xDEAD_BEEF -> word discarded, queue empty, next fetch 0x100 returns only its own data.
- Async reset asserted mid-WAIT between clock edges -> outputs 0 immediately; a stale rvalid after reset produces no push.
- With FETCH_MISALIGN_CHECK_EN: fetch 0x0000_0006 -> no mem_req, instr_fault=1, instr_pc=0x6, instr=0. Without the macro, mem_req issued for 0x6.
